// File: rtl/ram_pkg.sv
// Shared definitions for the 512x8 byte-addressable data memory.
// Holds the access-size codes, read/write polarity and the wrapping address helper.
package ram_pkg;

    localparam int RAM_DEPTH  = 512;
    localparam int RAM_ADDR_W = 9;

    localparam logic [5:0] OP_WORD = 6'b001000;
    localparam logic [5:0] OP_HALF = 6'b000010;
    localparam logic [5:0] OP_BYTE = 6'b000001;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Byte address k positions after a; wraps modulo the array size.
    function automatic logic [RAM_ADDR_W-1:0] next_addr(
        input logic [RAM_ADDR_W-1:0] a,
        input logic [1:0]            k
    );
        return a + RAM_ADDR_W'(k);
    endfunction

endpackage

// File: rtl/ram_512x8_if.sv
// Request/response bundle between a requester and the 512x8 data memory.
// master drives ReadWrite/Enable/Address/DataIn/OP; slave returns DataOut/MOC.
interface ram_512x8_if
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
);
    logic              ReadWrite;
    logic              Enable;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [5:0]        OP;
    logic [31:0]       DataOut;
    logic              MOC;

    modport master (
        output ReadWrite, Enable, Address, DataIn, OP,
        input  DataOut, MOC
    );

    modport slave (
        input  ReadWrite, Enable, Address, DataIn, OP,
        output DataOut, MOC
    );
endinterface

// File: rtl/ram_512x8.sv
// Byte-addressable 512x8 big-endian data memory with byte/halfword/word access.
// Ports: CLK, reset (sync, active-high), bus (slave: ReadWrite, Enable, Address, DataIn, OP -> DataOut, MOC).
module ram_512x8
    import ram_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic        CLK,
    input  logic        reset,
    ram_512x8_if.slave  bus
);

    logic [7:0] Mem [0:DEPTH-1];

    logic [31:0]       r_data;
    logic              r_moc;

    logic [ADDR_W-1:0] w_a0;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic              w_op_ok;
    logic [31:0]       w_rd_data;
    logic [3:0]        w_wr_en;
    logic [7:0]        w_wr_b0;
    logic [7:0]        w_wr_b1;
    logic [7:0]        w_wr_b2;
    logic [7:0]        w_wr_b3;
    logic              w_do_wr;

    // Address is the most significant byte; later lanes wrap.
    assign w_a0 = bus.Address;
    assign w_a1 = next_addr(bus.Address, 2'd1);
    assign w_a2 = next_addr(bus.Address, 2'd2);
    assign w_a3 = next_addr(bus.Address, 2'd3);

    // Byte-lane decode: read image and per-lane write strobes/data.
    always_comb begin
        w_op_ok   = 1'b1;
        w_rd_data = r_data;
        w_wr_en   = 4'b0000;
        w_wr_b0   = bus.DataIn[7:0];
        w_wr_b1   = bus.DataIn[7:0];
        w_wr_b2   = bus.DataIn[7:0];
        w_wr_b3   = bus.DataIn[7:0];
        case (bus.OP)
            OP_WORD: begin
                w_rd_data = {Mem[w_a0], Mem[w_a1], Mem[w_a2], Mem[w_a3]};
                w_wr_en   = 4'b1111;
                w_wr_b0   = bus.DataIn[31:24];
                w_wr_b1   = bus.DataIn[23:16];
                w_wr_b2   = bus.DataIn[15:8];
                w_wr_b3   = bus.DataIn[7:0];
            end
            OP_HALF: begin
                w_rd_data = {16'h0000, Mem[w_a0], Mem[w_a1]};
                w_wr_en   = 4'b0011;
                w_wr_b0   = bus.DataIn[15:8];
                w_wr_b1   = bus.DataIn[7:0];
            end
            OP_BYTE: begin
                w_rd_data = {24'h000000, Mem[w_a0]};
                w_wr_en   = 4'b0001;
                w_wr_b0   = bus.DataIn[7:0];
            end
            default: begin
                w_op_ok = 1'b0;
            end
        endcase
    end

    assign w_do_wr = !reset && bus.Enable && (bus.ReadWrite == RW_WRITE);

    // Control/response registers; unknown OP still completes so requesters never hang.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_data <= 32'h0;
            r_moc  <= 1'b0;
        end else if (bus.Enable) begin
            r_moc <= 1'b1;
            if (bus.ReadWrite == RW_READ && w_op_ok) begin
                r_data <= w_rd_data;
            end
        end else begin
            r_moc <= 1'b0;
        end
    end

    // Plain always so the array stays writable from a bench via hierarchy.
    always @(posedge CLK) begin
        if (w_do_wr) begin
            if (w_wr_en[0]) Mem[w_a0] <= w_wr_b0;
            if (w_wr_en[1]) Mem[w_a1] <= w_wr_b1;
            if (w_wr_en[2]) Mem[w_a2] <= w_wr_b2;
            if (w_wr_en[3]) Mem[w_a3] <= w_wr_b3;
        end
    end

    assign bus.DataOut = r_data;
    assign bus.MOC     = r_moc;

endmodule

// File: tb/tb_ram_512x8.sv
// Self-checking bench for ram_512x8: scoreboard of expected DataOut per operation.
// Tasks cover reset, reads, writes, narrow stores, wrap, reset priority, bad OP, back-to-back.
module tb_ram_512x8;
    import ram_pkg::*;

    logic CLK;
    logic reset;

    ram_512x8_if bus ();

    ram_512x8 dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q [$];
    logic [31:0] exp_d;

    task automatic drive(input logic rw, input logic [5:0] op,
                         input logic [8:0] a, input logic [31:0] d);
        @(negedge CLK);
        bus.ReadWrite = rw;
        bus.OP        = op;
        bus.Address   = a;
        bus.DataIn    = d;
        bus.Enable    = 1'b1;
        @(posedge CLK);
        #1;
        bus.Enable = 1'b0;
    endtask

    task automatic idle();
        @(negedge CLK);
        bus.Enable = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DataOut !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dataout got %h want %h", bus.DataOut, 32'h0);
        end
        n_checks++;
        if (bus.MOC !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_moc got %b want 0", bus.MOC);
        end
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_word_read();
        for (int i = 0; i < 12; i++) dut.Mem[i] = 8'(i + 1);
        exp_q.push_back(32'h01020304);
        drive(RW_READ, OP_WORD, 9'd0, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL word_read0 got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
        idle();
        n_checks++;
        if (bus.MOC !== 1'b0 || bus.DataOut !== exp_d) begin
            n_fail++;
            $display("FAIL moc_drop got %h/%b want %h/0", bus.DataOut, bus.MOC, exp_d);
        end
        exp_q.push_back(32'h05060708);
        drive(RW_READ, OP_WORD, 9'd4, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL word_read4 got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
    endtask

    task automatic test_write_read();
        exp_q.push_back(32'h05060708);
        drive(RW_WRITE, OP_WORD, 9'd16, 32'hDEADBEEF);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL write_hold got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
        exp_q.push_back(32'h000000AD);
        drive(RW_READ, OP_BYTE, 9'd17, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d) begin
            n_fail++;
            $display("FAIL byte_read17 got %h want %h", bus.DataOut, exp_d);
        end
        exp_q.push_back(32'h0000BEEF);
        drive(RW_READ, OP_HALF, 9'd18, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d) begin
            n_fail++;
            $display("FAIL half_read18 got %h want %h", bus.DataOut, exp_d);
        end
    endtask

    task automatic test_narrow_write();
        dut.Mem[19] = 8'h77;
        dut.Mem[21] = 8'h88;
        dut.Mem[24] = 8'h99;
        drive(RW_WRITE, OP_BYTE, 9'd20, 32'h123456AA);
        n_checks++;
        if ({dut.Mem[19], dut.Mem[20], dut.Mem[21]} !== 24'h77AA88) begin
            n_fail++;
            $display("FAIL byte_write got %h%h%h want 77aa88",
                     dut.Mem[19], dut.Mem[20], dut.Mem[21]);
        end
        drive(RW_WRITE, OP_HALF, 9'd22, 32'hFFFF5566);
        n_checks++;
        if ({dut.Mem[21], dut.Mem[22], dut.Mem[23], dut.Mem[24]} !== 32'h88556699) begin
            n_fail++;
            $display("FAIL half_write got %h%h%h%h want 88556699",
                     dut.Mem[21], dut.Mem[22], dut.Mem[23], dut.Mem[24]);
        end
    endtask

    task automatic test_reset_priority();
        exp_q.push_back(32'h0);
        @(negedge CLK);
        reset         = 1'b1;
        bus.ReadWrite = RW_WRITE;
        bus.OP        = OP_WORD;
        bus.Address   = 9'd8;
        bus.DataIn    = 32'h11111111;
        bus.Enable    = 1'b1;
        @(posedge CLK);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_prio_out got %h/%b want %h/0", bus.DataOut, bus.MOC, exp_d);
        end
        n_checks++;
        if ({dut.Mem[8], dut.Mem[9], dut.Mem[10], dut.Mem[11]} !== 32'h090A0B0C) begin
            n_fail++;
            $display("FAIL rst_prio_mem got %h%h%h%h want 090a0b0c",
                     dut.Mem[8], dut.Mem[9], dut.Mem[10], dut.Mem[11]);
        end
        @(negedge CLK);
        reset      = 1'b0;
        bus.Enable = 1'b0;
        exp_q.push_back(32'h05060708);
        drive(RW_READ, OP_WORD, 9'd4, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_read got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
    endtask

    task automatic test_wrap();
        drive(RW_WRITE, OP_WORD, 9'd510, 32'hA1B2C3D4);
        n_checks++;
        if ({dut.Mem[510], dut.Mem[511], dut.Mem[0], dut.Mem[1]} !== 32'hA1B2C3D4) begin
            n_fail++;
            $display("FAIL wrap_write got %h%h%h%h want a1b2c3d4",
                     dut.Mem[510], dut.Mem[511], dut.Mem[0], dut.Mem[1]);
        end
        n_checks++;
        if (dut.Mem[2] !== 8'h03) begin
            n_fail++;
            $display("FAIL wrap_spill got %h want 03", dut.Mem[2]);
        end
        exp_q.push_back(32'hA1B2C3D4);
        drive(RW_READ, OP_WORD, 9'd510, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d) begin
            n_fail++;
            $display("FAIL wrap_read got %h want %h", bus.DataOut, exp_d);
        end
    endtask

    task automatic test_bad_op();
        exp_q.push_back(32'hA1B2C3D4);
        drive(RW_WRITE, 6'b000100, 9'd4, 32'hFFFFFFFF);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL badop_wr got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
        n_checks++;
        if ({dut.Mem[4], dut.Mem[5], dut.Mem[6], dut.Mem[7]} !== 32'h05060708) begin
            n_fail++;
            $display("FAIL badop_mem got %h%h%h%h want 05060708",
                     dut.Mem[4], dut.Mem[5], dut.Mem[6], dut.Mem[7]);
        end
        exp_q.push_back(32'hA1B2C3D4);
        drive(RW_READ, 6'b000100, 9'd4, 32'h0);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL badop_rd got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        bus.ReadWrite = RW_WRITE;
        bus.OP        = OP_WORD;
        bus.Address   = 9'd100;
        bus.DataIn    = 32'h11223344;
        bus.Enable    = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_moc1 got %b want 1", bus.MOC);
        end
        exp_q.push_back(32'h11223344);
        @(negedge CLK);
        bus.ReadWrite = RW_READ;
        @(posedge CLK);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_read got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
        exp_q.push_back(32'h00003344);
        @(negedge CLK);
        bus.OP      = OP_HALF;
        bus.Address = 9'd102;
        @(posedge CLK);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++;
        if (bus.DataOut !== exp_d || bus.MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_half got %h/%b want %h/1", bus.DataOut, bus.MOC, exp_d);
        end
        idle();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.Enable    = 1'b0;
        bus.ReadWrite = RW_READ;
        bus.OP        = OP_WORD;
        bus.Address   = '0;
        bus.DataIn    = '0;
        test_reset();
        test_word_read();
        test_write_read();
        test_narrow_write();
        test_reset_priority();
        test_wrap();
        test_bad_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
